// File: rtl/v_upd_issue.sv
// v_upd_issue: in-order initiator for the v list-update bus.
// Buffers upstream update commands in a DEPTH-entry FIFO and issues them onto
// v's i_upd_* inputs at most one per cycle, honouring v's busy backpressure and
// a same-prod_id hazard window that matches the v update-pipeline depth.
module v_upd_issue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned HAZARD_N = 3,
    parameter int unsigned ID_W     = 8,
    parameter int unsigned CMD_W    = 4,
    parameter int unsigned KEY_W    = 32,
    parameter int unsigned SIZE_W   = 16
) (
    input  logic              clk,
    input  logic              arst,

    // Upstream command interface
    input  logic              i_req_vld,
    input  logic [ID_W-1:0]   i_req_prod_id,
    input  logic [CMD_W-1:0]  i_req_cmd,
    input  logic [KEY_W-1:0]  i_req_key,
    input  logic [SIZE_W-1:0] i_req_size,
    output logic              o_req_rdy,

    // Control
    input  logic              i_busy_r,
    input  logic              i_flush,

    // Update bus towards v
    output logic              o_upd_vld_r,
    output logic [ID_W-1:0]   o_upd_prod_id_r,
    output logic [CMD_W-1:0]  o_upd_cmd_r,
    output logic [KEY_W-1:0]  o_upd_key_r,
    output logic [SIZE_W-1:0] o_upd_size_r,

    // Status
    output logic [1:0]        o_state_r,
    output logic [31:0]       o_issue_cnt_r,
    output logic [31:0]       o_stall_cnt_r
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = ID_W + CMD_W + KEY_W + SIZE_W;
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2,
        StFlush = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State and next-state declarations
    // ------------------------------------------------------------------
    state_e              state_q, state_d;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [EW-1:0]       mem_d [DEPTH];
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;

    logic [HAZARD_N-1:0] haz_vld_q, haz_vld_d;
    logic [ID_W-1:0]     haz_id_q [HAZARD_N];
    logic [ID_W-1:0]     haz_id_d [HAZARD_N];

    logic                upd_vld_q, upd_vld_d;
    logic [ID_W-1:0]     upd_prod_id_q, upd_prod_id_d;
    logic [CMD_W-1:0]    upd_cmd_q, upd_cmd_d;
    logic [KEY_W-1:0]    upd_key_q, upd_key_d;
    logic [SIZE_W-1:0]   upd_size_q, upd_size_d;

    logic [31:0]         issue_cnt_q, issue_cnt_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // FIFO status and head decode
    // ------------------------------------------------------------------
    logic                empty;
    logic                full;
    logic                req_rdy;
    logic                push;
    logic                issue;
    logic                haz_hit;
    logic [EW-1:0]       head;
    logic [ID_W-1:0]     head_id;
    logic [CMD_W-1:0]    head_cmd;
    logic [KEY_W-1:0]    head_key;
    logic [SIZE_W-1:0]   head_size;
    logic [EW-1:0]       req_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign head = mem_q[rd_ptr_q[AW-1:0]];
    assign {head_id, head_cmd, head_key, head_size} = head;
    assign req_entry = {i_req_prod_id, i_req_cmd, i_req_key, i_req_size};

    // Ready is held low while reset is asserted, not just after it is sampled.
    assign req_rdy   = !arst && !full && (state_q != StFlush) && !i_flush;
    assign o_req_rdy = req_rdy;
    assign push      = i_req_vld && req_rdy;

    // Compare the head id against every live hazard entry
    always_comb begin
        haz_hit = 1'b0;
        for (int i = 0; i < int'(HAZARD_N); i++) begin
            if (haz_vld_q[i] && (haz_id_q[i] == head_id)) begin
                haz_hit = 1'b1;
            end
        end
    end

    // Strictly in-order: only the head may issue, never a younger entry.
    assign issue = !empty && !i_busy_r && (state_q != StFlush) && !i_flush && !haz_hit;

    // FIFO storage and pointer update; flush discards all queued entries
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush && (state_q != StFlush)) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = req_entry;
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
        end
    end

    // Hazard shift register: entry 0 records this cycle's issue
    always_comb begin
        haz_vld_d[0] = issue;
        haz_id_d[0]  = head_id;
        for (int i = 1; i < int'(HAZARD_N); i++) begin
            haz_vld_d[i] = haz_vld_q[i-1];
            haz_id_d[i]  = haz_id_q[i-1];
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (state_q == StFlush) begin
            if (!(|haz_vld_q) && !i_busy_r) begin
                state_d = StIdle;
            end
        end else if (i_flush) begin
            state_d = StFlush;
        end else if (wr_ptr_d == rd_ptr_d) begin
            state_d = StIdle;
        end else if (issue || (state_q == StIdle)) begin
            // First enqueue into an empty FIFO enters RUN directly.
            state_d = StRun;
        end else begin
            state_d = StStall;
        end
    end

    // Update-bus output registers; data holds between issues
    always_comb begin
        upd_vld_d     = issue;
        upd_prod_id_d = upd_prod_id_q;
        upd_cmd_d     = upd_cmd_q;
        upd_key_d     = upd_key_q;
        upd_size_d    = upd_size_q;
        if (issue) begin
            upd_prod_id_d = head_id;
            upd_cmd_d     = head_cmd;
            upd_key_d     = head_key;
            upd_size_d    = head_size;
        end
    end

    // Issue counter wraps; stall counter saturates
    always_comb begin
        issue_cnt_d = issue ? (issue_cnt_q + 32'd1) : issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == StStall) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Hazard window
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            haz_vld_q <= '0;
            for (int i = 0; i < int'(HAZARD_N); i++) begin
                haz_id_q[i] <= '0;
            end
        end else begin
            haz_vld_q <= haz_vld_d;
            for (int i = 0; i < int'(HAZARD_N); i++) begin
                haz_id_q[i] <= haz_id_d[i];
            end
        end
    end

    // FSM state, update outputs and counters
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= StIdle;
            upd_vld_q     <= 1'b0;
            upd_prod_id_q <= '0;
            upd_cmd_q     <= '0;
            upd_key_q     <= '0;
            upd_size_q    <= '0;
            issue_cnt_q   <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            upd_vld_q     <= upd_vld_d;
            upd_prod_id_q <= upd_prod_id_d;
            upd_cmd_q     <= upd_cmd_d;
            upd_key_q     <= upd_key_d;
            upd_size_q    <= upd_size_d;
            issue_cnt_q   <= issue_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign o_upd_vld_r     = upd_vld_q;
    assign o_upd_prod_id_r = upd_prod_id_q;
    assign o_upd_cmd_r     = upd_cmd_q;
    assign o_upd_key_r     = upd_key_q;
    assign o_upd_size_r    = upd_size_q;
    assign o_state_r       = state_q;
    assign o_issue_cnt_r   = issue_cnt_q;
    assign o_stall_cnt_r   = stall_cnt_q;

endmodule

// File: tb/tb_v_upd_issue.sv
// Directed testbench for v_upd_issue with hand-computed cycle expectations.
module tb_v_upd_issue;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        i_req_vld = 1'b0;
    logic [7:0]  i_req_prod_id = '0;
    logic [3:0]  i_req_cmd = '0;
    logic [31:0] i_req_key = '0;
    logic [15:0] i_req_size = '0;
    logic        o_req_rdy;
    logic        i_busy_r = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_upd_vld_r;
    logic [7:0]  o_upd_prod_id_r;
    logic [3:0]  o_upd_cmd_r;
    logic [31:0] o_upd_key_r;
    logic [15:0] o_upd_size_r;
    logic [1:0]  o_state_r;
    logic [31:0] o_issue_cnt_r;
    logic [31:0] o_stall_cnt_r;

    int checks = 0;
    int failures = 0;

    v_upd_issue #(
        .DEPTH    (8),
        .HAZARD_N (3),
        .ID_W     (8),
        .CMD_W    (4),
        .KEY_W    (32),
        .SIZE_W   (16)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .i_req_vld       (i_req_vld),
        .i_req_prod_id   (i_req_prod_id),
        .i_req_cmd       (i_req_cmd),
        .i_req_key       (i_req_key),
        .i_req_size      (i_req_size),
        .o_req_rdy       (o_req_rdy),
        .i_busy_r        (i_busy_r),
        .i_flush         (i_flush),
        .o_upd_vld_r     (o_upd_vld_r),
        .o_upd_prod_id_r (o_upd_prod_id_r),
        .o_upd_cmd_r     (o_upd_cmd_r),
        .o_upd_key_r     (o_upd_key_r),
        .o_upd_size_r    (o_upd_size_r),
        .o_state_r       (o_state_r),
        .o_issue_cnt_r   (o_issue_cnt_r),
        .o_stall_cnt_r   (o_stall_cnt_r)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [7:0] id, input logic [3:0] cmd,
                             input logic [31:0] key, input logic [15:0] sz);
        i_req_vld     = v;
        i_req_prod_id = id;
        i_req_cmd     = cmd;
        i_req_key     = key;
        i_req_size    = sz;
    endtask

    task automatic do_reset();
        arst     = 1'b1;
        i_busy_r = 1'b0;
        i_flush  = 1'b0;
        drive_req(1'b0, 8'd0, 4'd0, 32'd0, 16'd0);
        step();
        step();
        arst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        #2;
        checks++;
        if (o_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_rdy got=%0d exp=0", o_req_rdy);
        end
        checks++;
        if (o_upd_vld_r !== 1'b0 || o_state_r !== 2'd0) begin
            failures++;
            $display("FAIL reset_vld_state got=%0d/%0d exp=0/0", o_upd_vld_r, o_state_r);
        end
        checks++;
        if (o_issue_cnt_r !== 32'd0 || o_stall_cnt_r !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", o_issue_cnt_r, o_stall_cnt_r);
        end
        do_reset();
        checks++;
        if (o_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_rdy got=%0d exp=1", o_req_rdy);
        end
    endtask

    task automatic test_single();
        do_reset();
        drive_req(1'b1, 8'd2, 4'h9, 32'hBEEF_0001, 16'h0040);
        #1;
        checks++;
        if (o_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL single_rdy got=%0d exp=1", o_req_rdy);
        end
        step();
        i_req_vld = 1'b0;
        checks++;
        if (o_upd_vld_r !== 1'b0 || o_state_r !== 2'd1) begin
            failures++;
            $display("FAIL single_n1 vld/state got=%0d/%0d exp=0/1", o_upd_vld_r, o_state_r);
        end
        step();
        checks++;
        if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== 8'd2 || o_upd_cmd_r !== 4'h9 ||
            o_upd_key_r !== 32'hBEEF_0001 || o_upd_size_r !== 16'h0040) begin
            failures++;
            $display("FAIL single_n2 vld/id/cmd/key/size got=%0d/%0h/%0h/%0h/%0h exp=1/2/9/beef0001/40",
                     o_upd_vld_r, o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r);
        end
        checks++;
        if (o_issue_cnt_r !== 32'd1 || o_state_r !== 2'd0) begin
            failures++;
            $display("FAIL single_n2 cnt/state got=%0d/%0d exp=1/0", o_issue_cnt_r, o_state_r);
        end
        step();
        checks++;
        if (o_upd_vld_r !== 1'b0 || o_upd_prod_id_r !== 8'd2) begin
            failures++;
            $display("FAIL single_n3 vld/id_hold got=%0d/%0h exp=0/2", o_upd_vld_r, o_upd_prod_id_r);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_busy_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b1, 8'(i), 4'h3, 32'h1000 + 32'(i), 16'd8);
            #1;
            checks++;
            if (o_req_rdy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_fill_rdy[%0d] got=%0d exp=1", i, o_req_rdy);
            end
            step();
        end
        i_req_vld = 1'b0;
        checks++;
        if (o_req_rdy !== 1'b0 || o_upd_vld_r !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full rdy/vld got=%0d/%0d exp=0/0", o_req_rdy, o_upd_vld_r);
        end
        i_busy_r = 1'b0;
        #1;
        checks++;
        if (o_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full_with_pop_rdy got=%0d exp=0", o_req_rdy);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== 8'(i) ||
                o_upd_key_r !== 32'h1000 + 32'(i)) begin
                failures++;
                $display("FAIL b2b_issue[%0d] vld/id/key got=%0d/%0h/%0h exp=1/%0h/%0h",
                         i, o_upd_vld_r, o_upd_prod_id_r, o_upd_key_r, i, 32'h1000 + 32'(i));
            end
        end
        step();
        checks++;
        if (o_upd_vld_r !== 1'b0 || o_issue_cnt_r !== 32'd8 || o_state_r !== 2'd0) begin
            failures++;
            $display("FAIL b2b_end vld/cnt/state got=%0d/%0d/%0d exp=0/8/0",
                     o_upd_vld_r, o_issue_cnt_r, o_state_r);
        end
    endtask

    task automatic test_hazard();
        logic        exp_vld [7];
        logic [31:0] exp_key [7];
        exp_vld = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_key = '{32'hA1, 32'h0, 32'h0, 32'h0, 32'hA2, 32'hA3, 32'h0};
        do_reset();
        drive_req(1'b1, 8'd5, 4'd1, 32'hA1, 16'd1);
        step();
        drive_req(1'b1, 8'd5, 4'd2, 32'hA2, 16'd2);
        step();
        drive_req(1'b1, 8'd6, 4'd3, 32'hA3, 16'd3);
        // Cycles 2..8 after the first enqueue
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                step();
                i_req_vld = 1'b0;
            end
            checks++;
            if (o_upd_vld_r !== exp_vld[k] || (exp_vld[k] && o_upd_key_r !== exp_key[k])) begin
                failures++;
                $display("FAIL hazard_c%0d vld/key got=%0d/%0h exp=%0d/%0h",
                         k + 2, o_upd_vld_r, o_upd_key_r, exp_vld[k], exp_key[k]);
            end
            if (k == 2) begin
                checks++;
                if (o_state_r !== 2'd2) begin
                    failures++;
                    $display("FAIL hazard_stall_state got=%0d exp=2", o_state_r);
                end
            end
        end
        checks++;
        if (o_stall_cnt_r !== 32'd3 || o_issue_cnt_r !== 32'd3 || o_state_r !== 2'd0) begin
            failures++;
            $display("FAIL hazard_end stall/issue/state got=%0d/%0d/%0d exp=3/3/0",
                     o_stall_cnt_r, o_issue_cnt_r, o_state_r);
        end
    endtask

    task automatic test_busy();
        do_reset();
        i_busy_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 8'(i + 1), 4'd4, 32'h200 + 32'(i), 16'd4);
            step();
        end
        i_req_vld = 1'b0;
        // Now in cycle 3; hold busy through cycle 11
        for (int k = 3; k < 12; k++) begin
            checks++;
            if (o_upd_vld_r !== 1'b0) begin
                failures++;
                $display("FAIL busy_no_issue_c%0d got=%0d exp=0", k, o_upd_vld_r);
            end
            step();
        end
        checks++;
        if (o_stall_cnt_r !== 32'd10 || o_state_r !== 2'd2) begin
            failures++;
            $display("FAIL busy_stall stall/state got=%0d/%0d exp=10/2", o_stall_cnt_r, o_state_r);
        end
        i_busy_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== 8'(i + 1)) begin
                failures++;
                $display("FAIL busy_resume[%0d] vld/id got=%0d/%0h exp=1/%0h",
                         i, o_upd_vld_r, o_upd_prod_id_r, i + 1);
            end
        end
        step();
        checks++;
        if (o_upd_vld_r !== 1'b0 || o_issue_cnt_r !== 32'd3) begin
            failures++;
            $display("FAIL busy_end vld/cnt got=%0d/%0d exp=0/3", o_upd_vld_r, o_issue_cnt_r);
        end
    endtask

    task automatic test_flush();
        logic [1:0] exp_state [4];
        exp_state = '{2'd3, 2'd3, 2'd3, 2'd0};
        do_reset();
        i_busy_r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b1, 8'(10 + i), 4'd5, 32'h300 + 32'(i), 16'd5);
            step();
        end
        i_req_vld = 1'b0;
        i_busy_r  = 1'b0;
        step();
        // Cycle 6: head issued at the end of cycle 5
        checks++;
        if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== 8'd10) begin
            failures++;
            $display("FAIL flush_pre_issue vld/id got=%0d/%0h exp=1/a", o_upd_vld_r, o_upd_prod_id_r);
        end
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL flush_pulse_rdy got=%0d exp=0", o_req_rdy);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            i_flush = 1'b0;
            checks++;
            if (o_upd_vld_r !== 1'b0 || o_state_r !== exp_state[k]) begin
                failures++;
                $display("FAIL flush_c%0d vld/state got=%0d/%0d exp=0/%0d",
                         k + 7, o_upd_vld_r, o_state_r, exp_state[k]);
            end
            if (k == 0) begin
                checks++;
                if (o_req_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_state_rdy got=%0d exp=0", o_req_rdy);
                end
            end
        end
        checks++;
        if (o_req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_rdy got=%0d exp=1", o_req_rdy);
        end
        step();
        checks++;
        if (o_upd_vld_r !== 1'b0 || o_issue_cnt_r !== 32'd1 || o_state_r !== 2'd0) begin
            failures++;
            $display("FAIL flush_end vld/cnt/state got=%0d/%0d/%0d exp=0/1/0",
                     o_upd_vld_r, o_issue_cnt_r, o_state_r);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 8'(20 + i), 4'd6, 32'h400 + 32'(i), 16'd6);
            step();
        end
        i_req_vld = 1'b0;
        checks++;
        if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== 8'd21) begin
            failures++;
            $display("FAIL arst_pre vld/id got=%0d/%0h exp=1/15", o_upd_vld_r, o_upd_prod_id_r);
        end
        arst = 1'b1;
        #1;
        checks++;
        if (o_upd_vld_r !== 1'b0 || o_state_r !== 2'd0 || o_req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL arst_mid vld/state/rdy got=%0d/%0d/%0d exp=0/0/0",
                     o_upd_vld_r, o_state_r, o_req_rdy);
        end
        checks++;
        if (o_issue_cnt_r !== 32'd0 || o_stall_cnt_r !== 32'd0 || o_upd_prod_id_r !== 8'd0) begin
            failures++;
            $display("FAIL arst_mid cnt/stall/id got=%0d/%0d/%0h exp=0/0/0",
                     o_issue_cnt_r, o_stall_cnt_r, o_upd_prod_id_r);
        end
        step();
        arst = 1'b0;
        #1;
        drive_req(1'b1, 8'd7, 4'd7, 32'h777, 16'd7);
        step();
        i_req_vld = 1'b0;
        checks++;
        if (o_upd_vld_r !== 1'b0) begin
            failures++;
            $display("FAIL arst_post_n1 vld got=%0d exp=0", o_upd_vld_r);
        end
        step();
        checks++;
        if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== 8'd7 || o_upd_key_r !== 32'h777 ||
            o_issue_cnt_r !== 32'd1) begin
            failures++;
            $display("FAIL arst_post_n2 vld/id/key/cnt got=%0d/%0h/%0h/%0d exp=1/7/777/1",
                     o_upd_vld_r, o_upd_prod_id_r, o_upd_key_r, o_issue_cnt_r);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hazard();
        test_busy();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
